// File: rtl/hyst_level_switch.sv
// rtl/hyst_level_switch.sv - multi-level magnitude switch with programmable thresholds and hysteresis
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   data_in      signed sample
//   data_en      sample valid
//   param_in     parameter value
//   param_addr   parameter select: T[0..N-1], V[0..N], H
//   param_en     parameter write strobe (wins over data_en)
//   data_out     V[level] for the last accepted sample
//   data_en_out  one-cycle valid for data_out
//   level_out    current level index
//   level_chg    pulses with data_en_out when the level changed
module hyst_level_switch #(
   parameter int MSB               = 31,
   parameter int NUM_THRESH        = 3,
   parameter int DEFAULT_TRIG_STEP = 'h10,
   parameter int DEFAULT_HYST      = 'h4,
   parameter int ADDR_W            = 8,
   localparam int LW               = $clog2(NUM_THRESH + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic signed [MSB:0] data_in,
   input  logic                data_en,
   input  logic [MSB:0]        param_in,
   input  logic [ADDR_W-1:0]   param_addr,
   input  logic                param_en,
   output logic [MSB:0]        data_out,
   output logic                data_en_out,
   output logic [LW-1:0]       level_out,
   output logic                level_chg
);

   localparam int DW = MSB + 1;
   localparam logic [LW-1:0] ONE = LW'(1);

   logic [MSB:0]   thr [NUM_THRESH];
   logic [MSB:0]   val [NUM_THRESH+1];
   logic [MSB:0]   hyst;

   logic [MSB:0]   mag;
   logic [MSB+1:0] mag_h;
   logic [LW-1:0]  r_cnt;
   logic [LW-1:0]  d_cnt;
   logic [LW-1:0]  nxt;
   logic [MSB:0]   nxt_val;
   logic           accept;

   assign accept = data_en && !param_en;

   always_comb begin
      // Negating the most-negative value wraps back to 2^MSB, which read
      // as unsigned is exactly the magnitude we want.
      mag   = data_in[MSB] ? $unsigned(-data_in) : $unsigned(data_in);
      // One extra bit so a large magnitude plus H cannot wrap.
      mag_h = {1'b0, mag} + {1'b0, hyst};
      r_cnt = '0;
      d_cnt = '0;
      // Counting (rather than searching) keeps the result well defined
      // even when thresholds are not programmed in ascending order.
      for (int i = 0; i < NUM_THRESH; i++) begin
         if (mag > thr[i])
            r_cnt = r_cnt + ONE;
         if (mag_h > {1'b0, thr[i]})
            d_cnt = d_cnt + ONE;
      end
      nxt = level_out;
      if (r_cnt > level_out)
         nxt = r_cnt;
      else if (d_cnt < level_out)
         nxt = d_cnt;
      nxt_val = '0;
      for (int k = 0; k <= NUM_THRESH; k++) begin
         if (nxt == LW'(k))
            nxt_val = val[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_THRESH; i++)
            thr[i] <= DW'(DEFAULT_TRIG_STEP * (i + 1));
         for (int k = 0; k <= NUM_THRESH; k++)
            val[k] <= DW'(k);
         hyst <= DW'(DEFAULT_HYST);
      end else if (param_en) begin
         // Unmapped addresses match no entry and fall through harmlessly.
         for (int i = 0; i < NUM_THRESH; i++)
            if (param_addr == ADDR_W'(i))
               thr[i] <= param_in;
         for (int k = 0; k <= NUM_THRESH; k++)
            if (param_addr == ADDR_W'(NUM_THRESH + k))
               val[k] <= param_in;
         if (param_addr == ADDR_W'(2 * NUM_THRESH + 1))
            hyst <= param_in;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_out    <= '0;
         data_en_out <= 1'b0;
         level_out   <= '0;
         level_chg   <= 1'b0;
      end else if (accept) begin
         data_out    <= nxt_val;
         data_en_out <= 1'b1;
         level_out   <= nxt;
         level_chg   <= (nxt != level_out);
      end else begin
         data_en_out <= 1'b0;
         level_chg   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_hyst_level_switch.sv
// tb/tb_hyst_level_switch.sv - scoreboard bench for hyst_level_switch
module tb_hyst_level_switch;

   logic               clk;
   logic               rst_n;
   logic signed [31:0] data_in;
   logic               data_en;
   logic [31:0]        param_in;
   logic [7:0]         param_addr;
   logic               param_en;
   logic [31:0]        data_out;
   logic               data_en_out;
   logic [1:0]         level_out;
   logic               level_chg;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  level;
      logic        chg;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   next_id = 0;

   hyst_level_switch dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .data_in     (data_in),
      .data_en     (data_en),
      .param_in    (param_in),
      .param_addr  (param_addr),
      .param_en    (param_en),
      .data_out    (data_out),
      .data_en_out (data_en_out),
      .level_out   (level_out),
      .level_chg   (level_chg)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance to the next falling edge and retire any output the DUT produced.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (data_en_out === 1'b1) begin
         if (sb.size() == 0) begin
            check("unexpected_out", 32'(data_en_out), 32'd0);
         end else begin
            e = sb.pop_front();
            check($sformatf("out_data#%0d", e.id), data_out, e.data);
            check($sformatf("out_level#%0d", e.id), 32'(level_out), 32'(e.level));
            check($sformatf("out_chg#%0d", e.id), 32'(level_chg), 32'(e.chg));
         end
      end
   endtask

   task automatic sample(input logic [31:0] v, input logic [31:0] ed, input logic [1:0] el, input logic ec);
      exp_t e;
      tick();
      data_in  = v;
      data_en  = 1'b1;
      param_en = 1'b0;
      e.data   = ed;
      e.level  = el;
      e.chg    = ec;
      e.id     = next_id;
      next_id++;
      sb.push_back(e);
   endtask

   task automatic param(input logic [7:0] a, input logic [31:0] v, input logic with_sample, input logic [31:0] sv);
      tick();
      param_en   = 1'b1;
      param_addr = a;
      param_in   = v;
      data_en    = with_sample;
      data_in    = sv;
   endtask

   task automatic idle();
      tick();
      data_en  = 1'b0;
      param_en = 1'b0;
   endtask

   initial begin
      rst_n      = 1'b0;
      data_in    = '0;
      data_en    = 1'b0;
      param_in   = '0;
      param_addr = '0;
      param_en   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_data", data_out, 32'd0);
      check("rst_en", 32'(data_en_out), 32'd0);
      check("rst_level", 32'(level_out), 32'd0);
      check("rst_chg", 32'(level_chg), 32'd0);
      rst_n = 1'b1;

      // low sample then idle
      sample(32'd10, 32'd0, 2'd0, 1'b0);
      idle();
      idle();
      check("idle_en", 32'(data_en_out), 32'd0);
      check("idle_chg", 32'(level_chg), 32'd0);

      // rise and hysteresis, back-to-back
      sample(32'd40, 32'd2, 2'd2, 1'b1);
      sample(32'd30, 32'd2, 2'd2, 1'b0);
      sample(32'd27, 32'd1, 2'd1, 1'b1);

      // boundaries: equal counts as below, negative uses magnitude
      sample(32'd0,  32'd0, 2'd0, 1'b1);
      sample(32'd16, 32'd0, 2'd0, 1'b0);
      sample(32'd17, 32'd1, 2'd1, 1'b1);
      sample(-32'sd48, 32'd2, 2'd2, 1'b1);

      // most-negative input, then straight back to level 0
      sample(32'h8000_0000, 32'd3, 2'd3, 1'b1);
      sample(32'd0, 32'd0, 2'd0, 1'b1);
      idle();
      idle();
      check("hold_en", 32'(data_en_out), 32'd0);
      check("hold_data", data_out, 32'd0);
      check("hold_level", 32'(level_out), 32'd0);

      // parameter write beats a simultaneous sample
      param(8'd0, 32'd100, 1'b1, 32'd50);
      idle();
      check("prio_en", 32'(data_en_out), 32'd0);
      check("prio_level", 32'(level_out), 32'd0);
      sample(32'd50, 32'd2, 2'd2, 1'b1);

      // unmapped address, then H=0 lets 47 fall below T[2]=48
      param(8'd9, 32'd0, 1'b0, 32'd0);
      param(8'd7, 32'd0, 1'b0, 32'd0);
      sample(32'd47, 32'd1, 2'd1, 1'b1);

      // program V[3], reach level 3
      param(8'd6, 32'h55, 1'b0, 32'd0);
      sample(32'd200, 32'h55, 2'd3, 1'b1);
      idle();
      idle();
      check("pre_rst_level", 32'(level_out), 32'd3);
      check("pre_rst_data", data_out, 32'h55);

      // asynchronous reset between edges
      tick();
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_data", data_out, 32'd0);
      check("async_rst_level", 32'(level_out), 32'd0);
      check("async_rst_en", 32'(data_en_out), 32'd0);
      check("async_rst_chg", 32'(level_chg), 32'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // defaults restored: T=16,32,48 and V[3]=3
      sample(32'd60, 32'd3, 2'd3, 1'b1);
      idle();
      idle();
      check("sb_drain", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
